// File: rtl/macu_pkg.sv
// Shared helpers for the DCT multiply-accumulate unit: width derivation and
// the rounding / shifting / saturating result scaler.
package macu_pkg;

  localparam int MAXW = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calc_aw(input int dwidth, input int cwidth, input int taps);
    return dwidth + cwidth + clog2(taps);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_max(input int rwidth);
    logic signed [MAXW-1:0] one;
    one = MAXW'(1);
    return (one <<< (rwidth - 1)) - one;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_min(input int rwidth);
    logic signed [MAXW-1:0] one;
    one = MAXW'(1);
    return -(one <<< (rwidth - 1));
  endfunction

  // Evaluated at full MAXW precision so the rounding add can never overflow.
  function automatic logic signed [MAXW-1:0] round_shift_sat(
    input logic signed [MAXW-1:0] value,
    input int                     aw,
    input int                     rwidth,
    input int                     shift,
    input bit                     round_en,
    input bit                     sat_en
  );
    logic signed [MAXW-1:0] v;
    logic signed [MAXW-1:0] one;
    one = MAXW'(1);
    v = (value <<< (MAXW - aw)) >>> (MAXW - aw);
    if (round_en && shift > 0) v = v + (one <<< (shift - 1));
    v = v >>> shift;
    if (sat_en) begin
      if (v > sat_max(rwidth)) v = sat_max(rwidth);
      else if (v < sat_min(rwidth)) v = sat_min(rwidth);
    end else begin
      v = (v <<< (MAXW - rwidth)) >>> (MAXW - rwidth);
    end
    return v;
  endfunction

endpackage

// File: rtl/macu_finalize.sv
// Combinational result scaler: rounds, shifts and saturates (or wraps) the
// AW-bit block sum down to the RWIDTH-bit result.
module macu_finalize #(
  parameter int AW     = 27,
  parameter int RWIDTH = 12,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 1,
  parameter int SAT    = 1
) (
  input  logic signed [AW-1:0]     sum,
  output logic signed [RWIDTH-1:0] result
);
  import macu_pkg::*;

  assign result = RWIDTH'(round_shift_sat(MAXW'(sum), AW, RWIDTH, SHIFT,
                                          ROUND != 0, SAT != 0));

endmodule

// File: rtl/dct_macu_pipe.sv
// Pipelined multiply-accumulate for the forward DCT: one scaled coefficient per
// TAPS accepted sample/coefficient pairs, with a valid/ready result port.
module dct_macu_pipe #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16,
  parameter int TAPS   = 8,
  parameter int RWIDTH = 12,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 1,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_first,
  input  logic signed [DWIDTH-1:0] s_data,
  input  logic signed [CWIDTH-1:0] s_coef,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [RWIDTH-1:0] m_result,
  output logic                     err_restart
);
  import macu_pkg::*;

  localparam int PW   = DWIDTH + CWIDTH;
  localparam int AW   = calc_aw(DWIDTH, CWIDTH, TAPS);
  localparam int CNTW = clog2(TAPS);
  localparam logic [CNTW-1:0] LAST_TAP = CNTW'(TAPS - 1);

  logic                     adv;
  logic                     accept;
  logic                     restart;
  logic                     tap_last;
  logic [CNTW-1:0]          cnt;
  logic [CNTW-1:0]          tap_idx;
  logic signed [PW-1:0]     p_q;
  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [AW-1:0]     acc_q;
  logic signed [AW-1:0]     sum;
  logic signed [RWIDTH-1:0] fin;

  // A full, unread result freezes the whole pipeline so nothing is lost.
  assign adv      = !(m_valid && !m_ready);
  assign s_ready  = adv;
  assign accept   = s_valid && adv;
  assign tap_idx  = s_first ? '0 : cnt;
  assign tap_last = (tap_idx == LAST_TAP);
  assign restart  = s_first && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      err_restart <= 1'b0;
    end else begin
      err_restart <= accept && restart;
      if (accept) cnt <= tap_last ? '0 : tap_idx + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (adv) begin
      p_q     <= PW'(s_data) * PW'(s_coef);
      p_valid <= s_valid;
      p_first <= (tap_idx == '0);
      p_last  <= tap_last;
    end
  end

  // Tap 0 restarts the accumulation, which also discards any partial block.
  always_comb begin
    sum = (p_first ? '0 : acc_q) + AW'(p_q);
  end

  macu_finalize #(
    .AW     (AW),
    .RWIDTH (RWIDTH),
    .SHIFT  (SHIFT),
    .ROUND  (ROUND),
    .SAT    (SAT)
  ) u_finalize (
    .sum    (sum),
    .result (fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      m_result <= '0;
      m_valid  <= 1'b0;
    end else begin
      if (adv && p_valid) acc_q <= sum;
      if (adv && p_valid && p_last) begin
        m_result <= fin;
        m_valid  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_macu_pipe.sv
// Randomised self-checking bench: four scaling configurations share one input
// stream and are scored against a block-sum reference model.
module tb_dct_macu_pipe;

  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_first = 1'b0;
  logic m_ready = 1'b1;
  logic signed [7:0]  s_data = '0;
  logic signed [15:0] s_coef = '0;
  logic [3:0]         sr;
  logic [3:0]         mv;
  logic [3:0]         er;
  logic [3:0][11:0]   mres;

  int     checks = 0;
  int     errors = 0;
  longint exp_q[$];
  int     mcnt = 0;
  longint msum = 0;
  bit     err_set = 1'b0;
  int     sr_low = 0;
  int     err_pulses = 0;
  bit     bp_arm = 1'b0;
  int     bp_left = 0;
  bit     rand_ready = 1'b0;

  always #5 clk = ~clk;

  dct_macu_pipe #(.SHIFT(0), .ROUND(1), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[0]), .s_first(s_first),
    .s_data(s_data), .s_coef(s_coef), .m_valid(mv[0]), .m_ready(m_ready),
    .m_result(mres[0]), .err_restart(er[0]));
  dct_macu_pipe #(.SHIFT(0), .ROUND(1), .SAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[1]), .s_first(s_first),
    .s_data(s_data), .s_coef(s_coef), .m_valid(mv[1]), .m_ready(m_ready),
    .m_result(mres[1]), .err_restart(er[1]));
  dct_macu_pipe #(.SHIFT(4), .ROUND(1), .SAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[2]), .s_first(s_first),
    .s_data(s_data), .s_coef(s_coef), .m_valid(mv[2]), .m_ready(m_ready),
    .m_result(mres[2]), .err_restart(er[2]));
  dct_macu_pipe #(.SHIFT(4), .ROUND(0), .SAT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[3]), .s_first(s_first),
    .s_data(s_data), .s_coef(s_coef), .m_valid(mv[3]), .m_ready(m_ready),
    .m_result(mres[3]), .err_restart(er[3]));

  function automatic int cfg_shift(input int i);
    return (i >= 2) ? 4 : 0;
  endfunction

  function automatic bit cfg_round(input int i);
    return i != 3;
  endfunction

  function automatic bit cfg_sat(input int i);
    return i != 1;
  endfunction

  // Scaled result from the exact block sum, using floor division and modulo.
  function automatic int expect_result(input longint sum, input int i);
    longint v;
    longint div;
    v = sum;
    div = longint'(1) << cfg_shift(i);
    if (cfg_round(i) && cfg_shift(i) > 0) v = v + div / 2;
    if (v >= 0) v = v / div;
    else v = -((-v + div - 1) / div);
    if (cfg_sat(i)) begin
      if (v > 2047) v = 2047;
      else if (v < -2048) v = -2048;
    end else begin
      v = v % 4096;
      if (v < 0) v = v + 4096;
      if (v >= 2048) v = v - 4096;
    end
    return int'(v);
  endfunction

  task automatic model_accept(input logic signed [7:0] d, input logic signed [15:0] c,
                              input logic f);
    if (f && mcnt != 0) err_set = 1'b1;
    if (f || mcnt == 0) begin
      mcnt = 0;
      msum = 0;
    end
    msum = msum + longint'(d) * longint'(c);
    mcnt++;
    if (mcnt == TAPS) begin
      exp_q.push_back(msum);
      mcnt = 0;
    end
  endtask

  task automatic monitor();
    longint s;
    int     e;
    forever begin
      @(negedge clk);
      if (sr[0] !== 1'b1) sr_low++;
      if (er[0] === 1'b1) err_pulses++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (er[i] !== err_set) begin
          errors++;
          $display("[TB] FAIL err_restart dut%0d: got %b expected %b", i, er[i], err_set);
        end
      end
      err_set = 1'b0;
      if (m_ready === 1'b1 && mv != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stray_valid: got m_valid=%b expected 0000", mv);
        end else begin
          s = exp_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            e = expect_result(s, i);
            checks++;
            if (mv[i] !== 1'b1 || $signed(mres[i]) !== e) begin
              errors++;
              $display("[TB] FAIL result dut%0d: got valid=%b value=%0d expected valid=1 value=%0d",
                       i, mv[i], $signed(mres[i]), e);
            end
          end
        end
      end
    end
  endtask

  task automatic ready_ctl();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        m_ready = ($urandom_range(0, 3) != 0);
      end else if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) m_ready = 1'b1;
      end else if (bp_arm && mv[0] === 1'b1) begin
        m_ready = 1'b0;
        bp_left = 5;
        bp_arm  = 1'b0;
      end
    end
  endtask

  task automatic send_pair(input logic signed [7:0] d, input logic signed [15:0] c,
                           input logic f);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_coef  = c;
    s_first = f;
    forever begin
      @(negedge clk);
      if (sr[0] === 1'b1) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got s_ready=%b expected 1", sr[0]);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (waited <= 200) model_accept(d, c, f);
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic send_block(input logic signed [7:0] d, input logic signed [15:0] c);
    for (int k = 0; k < TAPS; k++) send_pair(d, c, k == 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mv[i] !== 1'b0 || er[i] !== 1'b0 || mres[i] !== 12'd0 || sr[i] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: got v=%b e=%b r=%0d rdy=%b expected 0 0 0 1",
                 i, mv[i], er[i], mres[i], sr[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_block(8'sd1, 16'sd2);
    @(negedge clk);
    checks++;
    if (mv[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got m_valid=%b expected 0", mv[0]);
    end
    @(negedge clk);
    checks++;
    if (mv[0] !== 1'b1 || $signed(mres[0]) !== 16) begin
      errors++;
      $display("[TB] FAIL latency: got valid=%b value=%0d expected valid=1 value=16",
               mv[0], $signed(mres[0]));
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    send_block(8'sd127, 16'sd32767);
    send_block(-8'sd128, 16'sd32767);
    wait_drain();
  endtask

  task automatic test_shift();
    for (int k = 0; k < TAPS; k++) send_pair(8'sd3, 16'sd1, k == 0);
    for (int k = 0; k < TAPS; k++) send_pair((k == TAPS - 1) ? 8'sd2 : 8'sd3, 16'sd1, k == 0);
    for (int k = 0; k < TAPS; k++) send_pair((k == TAPS - 1) ? -8'sd2 : -8'sd1, 16'sd1, k == 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    sr_low = 0;
    bp_arm = 1'b1;
    send_block(8'sd1, 16'sd2);
    send_block(8'sd2, 16'sd2);
    wait_drain();
    checks++;
    if (sr_low != 5) begin
      errors++;
      $display("[TB] FAIL backpressure_cycles: got %0d expected 5", sr_low);
    end
  endtask

  task automatic test_restart();
    err_pulses = 0;
    for (int k = 0; k < 3; k++) send_pair(8'($urandom), 16'($urandom), k == 0);
    send_block(8'sd1, 16'sd1);
    wait_drain();
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("[TB] FAIL restart_pulses: got %0d expected 1", err_pulses);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) send_pair(8'($urandom), 16'($urandom), k == 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mcnt = 0;
    msum = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mv[i] !== 1'b0 || er[i] !== 1'b0 || mres[i] !== 12'd0) begin
        errors++;
        $display("[TB] FAIL async_reset dut%0d: got v=%b e=%b r=%0d expected 0 0 0",
                 i, mv[i], er[i], mres[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < TAPS; k++) send_pair(8'($urandom), 16'($urandom), 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_pair(8'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    fork
      monitor();
      ready_ctl();
      begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none
    test_reset();
    test_basic();
    test_saturation();
    test_shift();
    test_back_to_back();
    test_restart();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
